// File: rtl/shift_add_multiply_pkg.sv
// Shared definitions for the radix-2 shift-and-add multiplier.
// Holds the FSM state encoding, default operand width and counter sizing.
package shift_add_multiply_pkg;

    localparam int DEF_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shift_add_multiply.sv
// Sequential unsigned multiplier, radix-2 shift-and-add, one partial product per cycle.
// Latency: product and done pulse appear WIDTH+1 edges after the accepted start edge.
// Backpressure: start is only accepted in IDLE and ignored otherwise; busy flags a running operation.
module shift_add_multiply
    import shift_add_multiply_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_reg;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_step;
    logic [WIDTH:0]     sum;
    logic               last_iter;

    // The carry out of the upper-half add lands in the MSB after the shift,
    // so it never needs to be held across cycles.
    always_comb begin
        sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_reg} : '0);
        p_step = {sum, p[WIDTH-1:1]};
    end

    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_reg <= '0;
            p     <= '0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg <= multiplicand;
                        p     <= {{WIDTH{1'b0}}, multiplier};
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    p   <= p_step;
                    cnt <= cnt + 1'b1;
                end
                ST_DONE: begin
                    out <= p;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiply.sv
// Bench for shift_add_multiply: directed vector table, corner sequences and random products.
module tb_shift_add_multiply;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    multiplier;
    logic [W-1:0]    multiplicand;
    logic [2*W-1:0]  out;
    logic            busy;
    logic            done;

    int pass_cnt = 0;
    int total    = 0;
    int overlap  = 0;

    shift_add_multiply #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .out          (out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done && busy) overlap++;

    typedef struct {
        logic [W-1:0]   b;
        logic [W-1:0]   a;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa, wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    // Launch one multiply, wait for done; lat = -1 if the budget expires.
    task automatic run_one(input logic [W-1:0] b, input logic [W-1:0] a, input bit chg,
                           output int lat, output int bcnt);
        bit got;
        int k;
        @(negedge clk);
        multiplier   = b;
        multiplicand = a;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (chg) begin
            multiplier   = $urandom;
            multiplicand = $urandom;
        end
        bcnt = busy ? 1 : 0;
        k    = 0;
        got  = 0;
        while (k < 80 && !got) begin
            @(posedge clk);
            #1;
            k++;
            if (done) got = 1;
            else if (busy) bcnt++;
        end
        lat = got ? k : -1;
    endtask

    // Count done pulses over n cycles.
    task automatic count_done(input int n, output int dcnt);
        dcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, dcnt, k, t1, t2;
        logic [2*W-1:0] r1, r2;
        logic [W-1:0] ra, rb;

        tbl[0] = '{b: 32'd3,          a: 32'd4,          exp: 64'd12};
        tbl[1] = '{b: 32'hFFFFFFFF,   a: 32'hFFFFFFFF,   exp: 64'hFFFFFFFE00000001};
        tbl[2] = '{b: 32'd0,          a: 32'h12345678,   exp: 64'd0};
        tbl[3] = '{b: 32'd7,          a: 32'd6,          exp: 64'd42};
        tbl[4] = '{b: 32'h80000000,   a: 32'd2,          exp: 64'h100000000};
        tbl[5] = '{b: 32'h12345678,   a: 32'h9ABCDEF0,   exp: 64'h0B00EA4E242D2080};

        rst = 1'b1; start = 1'b0; multiplier = '0; multiplicand = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", out, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_one(tbl[i].b, tbl[i].a, 1'b1, lat, bcnt);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd33);
            chk($sformatf("vec%0d_out", i), out, tbl[i].exp);
            chk($sformatf("vec%0d_busycycles", i), 64'(bcnt), 64'd32);
            chk($sformatf("vec%0d_busy_after", i), {63'd0, busy}, 64'd0);
        end

        // start pulsed mid-run must be ignored
        @(negedge clk);
        multiplier = 32'd3; multiplicand = 32'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 0; lat = -1;
        while (k < 80 && lat < 0) begin
            @(posedge clk); #1; k++;
            if (k == 10) begin multiplier = 32'd100; multiplicand = 32'd100; start = 1'b1; end
            if (k == 11) start = 1'b0;
            if (done) lat = k;
        end
        chk("ignore_lat", 64'(lat), 64'd33);
        chk("ignore_out", out, 64'd12);
        count_done(45, dcnt);
        chk("ignore_no_second_done", 64'(dcnt), 64'd0);

        // reset mid-operation
        @(negedge clk);
        multiplier = 32'hDEADBEEF; multiplicand = 32'h1234; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("midrst_out", out, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        count_done(45, dcnt);
        chk("midrst_no_done", 64'(dcnt), 64'd0);
        run_one(32'd7, 32'd6, 1'b0, lat, bcnt);
        chk("after_rst_out", out, 64'd42);

        // start together with reset: nothing begins
        @(negedge clk);
        multiplier = 32'd9; multiplicand = 32'd9; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1; start = 1'b0; rst = 1'b0;
        chk("rst_start_busy", {63'd0, busy}, 64'd0);
        count_done(45, dcnt);
        chk("rst_start_no_done", 64'(dcnt), 64'd0);
        chk("rst_start_out", out, 64'd0);

        // back-to-back with start held high
        @(negedge clk);
        multiplier = 32'd5; multiplicand = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        multiplier = 32'h10000; multiplicand = 32'h10000;
        k = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        while (k < 120 && t2 < 0) begin
            @(posedge clk); #1; k++;
            if (k == 36) start = 1'b0;
            if (done && t1 < 0) begin t1 = k; r1 = out; end
            else if (done) begin t2 = k; r2 = out; end
        end
        start = 1'b0;
        chk("b2b_first_lat", 64'(t1), 64'd33);
        chk("b2b_first_out", r1, 64'd45);
        chk("b2b_second_out", r2, 64'h100000000);
        chk("b2b_spacing", 64'(t2 - t1), 64'd34);
        count_done(45, dcnt);
        chk("b2b_no_third", 64'(dcnt), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) ra = '1;
            if (i % 10 == 1) rb = '0;
            run_one(rb, ra, 1'b1, lat, bcnt);
            if (lat != 33) chk($sformatf("rand%0d_lat", i), 64'(lat), 64'd33);
            chk($sformatf("rand%0d_out", i), out, ref_mul(ra, rb));
        end

        chk("done_busy_overlap", 64'(overlap), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
